// File: rtl/pipelined_cla_adder.sv
// Purpose: pipelined carry-lookahead adder (ADD/SUB/SATADD/ADDC) with 4-bit CLA groups split across stages.
// Latency: S = ceil((WIDTH/4)/GROUPS_PER_STAGE) register stages, counting the acceptance edge.
// Backpressure: whole pipeline advances only when ~out_valid | out_ready; in_ready mirrors that enable.
module pipelined_cla_adder #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int G  = WIDTH / 4;
    localparam int S  = (G + GROUPS_PER_STAGE - 1) / GROUPS_PER_STAGE;
    localparam int NQ = (S > 1) ? S - 1 : 1;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_SAT  = 2'b10;
    localparam logic [1:0] MODE_ADDC = 2'b11;

    // One beat in flight: effective operands travel with the partial sum and the inter-stage carry.
    typedef struct packed {
        logic             vld;
        logic [1:0]       mode;
        logic             cy;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
    } stage_t;

    stage_t stg_in;
    stage_t stg_src [S];
    stage_t stg_d   [S];
    stage_t stg_q   [NQ];
    stage_t fin;

    logic             adv;
    logic             fin_msb_cin;
    logic             fin_ovf;
    logic [WIDTH-1:0] fin_sum;

    // 4-bit lookahead group: returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [4:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Map the operation onto a plain A + B' + c0 addition; mode and cin are captured here with the beat.
    always_comb begin
        stg_in      = '0;
        stg_in.vld  = in_valid;
        stg_in.mode = mode;
        stg_in.a    = a;
        stg_in.b    = (mode == MODE_SUB) ? ~b : b;
        stg_in.cy   = (mode == MODE_SUB) | ((mode == MODE_ADDC) & cin);
    end

    // Source of each stage: stage 0 takes the new beat, later stages take the previous stage register.
    always_comb begin
        stg_src[0] = stg_in;
        for (int k = 1; k < S; k++) begin
            stg_src[k] = stg_q[k-1];
        end
    end

    // Each stage resolves its own slice of groups, chaining the carry through them.
    always_comb begin
        logic       cy;
        logic [4:0] r;
        cy = 1'b0;
        r  = '0;
        for (int k = 0; k < S; k++) begin
            stg_d[k] = stg_src[k];
            cy       = stg_src[k].cy;
            for (int g = 0; g < G; g++) begin
                if ((g >= k * GROUPS_PER_STAGE) && (g < (k + 1) * GROUPS_PER_STAGE)) begin
                    r                    = cla4(stg_src[k].a[g*4 +: 4], stg_src[k].b[g*4 +: 4], cy);
                    stg_d[k].s[g*4 +: 4] = r[3:0];
                    cy                   = r[4];
                end
            end
            stg_d[k].cy = cy;
        end
    end

    // Final stage: flags from the raw result, then saturation, then zero detect on the saturated value.
    always_comb begin
        fin         = stg_d[S-1];
        fin_msb_cin = fin.s[WIDTH-1] ^ fin.a[WIDTH-1] ^ fin.b[WIDTH-1];
        fin_ovf     = fin_msb_cin ^ fin.cy;
        fin_sum     = fin.s;
        if ((fin.mode == MODE_SAT) && fin_ovf) begin
            fin_sum = fin.s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    // Stage and output registers: synchronous reset wins, otherwise everything moves together on adv.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NQ; k++) begin
                stg_q[k] <= '0;
            end
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < S - 1; k++) begin
                stg_q[k] <= stg_d[k];
            end
            out_valid <= fin.vld;
            sum       <= fin_sum;
            cout      <= fin.cy;
            ovf       <= fin_ovf;
            zero      <= (fin_sum == '0);
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=16, two groups per stage, two stages).
// Arithmetic reference model plus scoreboard queue, checked on every output handshake.
// Directed vectors, a stalled random stream and a mid-flight reset.
module tb_pipelined_cla_adder;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          zero;

    int total = 0;
    int bad   = 0;

    pipelined_cla_adder #(.WIDTH(16), .GROUPS_PER_STAGE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        res_t r;
        int   acc;
        int   stl;
    } exp_t;

    // Reference: plain 17-bit arithmetic, signed overflow from operand/result signs.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic [1:0] m, input logic c);
        logic [15:0] yy;
        logic        ci;
        logic [16:0] full;
        res_t        r;
        yy     = (m == 2'b01) ? ~y : y;
        ci     = (m == 2'b01) ? 1'b1 : ((m == 2'b11) ? c : 1'b0);
        full   = {1'b0, x} + {1'b0, yy} + {16'd0, ci};
        r.cout = full[16];
        r.ovf  = (x[15] == yy[15]) && (full[15] != x[15]);
        r.sum  = full[15:0];
        if (m == 2'b10 && r.ovf) r.sum = full[15] ? 16'h7FFF : 16'h8000;
        r.zero = (r.sum == 16'h0000);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic pin(input logic [15:0] x, input logic [15:0] y, input logic [1:0] m,
                       input logic c, input res_t exp);
        res_t r;
        r = model(x, y, m, c);
        check("model_pin", {13'd0, r}, {13'd0, exp});
    endtask

    // Scoreboard and per-cycle checks, sampled on the falling edge.
    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   stalls = 0;
    int   head_since = 0;
    int   lat;
    logic prev_stall = 1'b0;
    res_t snap;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready_eq_adv", in_ready, !out_valid || out_ready);
            if (prev_stall) check("hold_fields", {13'd0, sum, cout, ovf, zero}, {13'd0, snap});
            if (out_valid && !prev_stall) head_since = cyc;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat got sum=%h exp=none", sum);
                end else begin
                    e = q.pop_front();
                    check("sum",  sum,  e.r.sum);
                    check("cout", cout, e.r.cout);
                    check("ovf",  ovf,  e.r.ovf);
                    check("zero", zero, e.r.zero);
                    lat = head_since - e.acc;
                    if (e.stl == stalls) check("latency", lat, 2);
                    else check("latency_min", lat >= 2, 1);
                end
            end
            if (in_valid && in_ready) begin
                e.r   = model(a, b, mode, cin);
                e.acc = cyc;
                e.stl = stalls;
                q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                stalls++;
                snap = {sum, cout, ovf, zero};
            end
        end
    end

    // Drive one beat from posedge+1 and return at posedge+1 after it was taken.
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [1:0] m, input logic c);
        int w;
        a = x; b = y; mode = m; cin = c; in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout got in_ready=0 exp=1");
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [15:0] x, input logic [15:0] y, input logic [1:0] m, input logic c);
        send(x, y, m, c);
        idle(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {cout, ovf, zero}, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pin(16'h1234, 16'h0FFF, 2'b00, 1'b0, {16'h2233, 1'b0, 1'b0, 1'b0});
        pin(16'h0005, 16'h0005, 2'b01, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1});
        pin(16'h0000, 16'h0001, 2'b01, 1'b0, {16'hFFFF, 1'b0, 1'b0, 1'b0});
        pin(16'h7FFF, 16'h0001, 2'b10, 1'b0, {16'h7FFF, 1'b0, 1'b1, 1'b0});
        pin(16'h8000, 16'hFFFF, 2'b10, 1'b0, {16'h8000, 1'b1, 1'b1, 1'b0});
        pin(16'h7FFF, 16'h0001, 2'b00, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0});
        pin(16'hFFFF, 16'h0000, 2'b11, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b1});
        pin(16'h0001, 16'h0001, 2'b00, 1'b1, {16'h0002, 1'b0, 1'b0, 1'b0});

        // First beat with literal latency and value checks.
        a = 16'h1234; b = 16'h0FFF; mode = 2'b00; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_mid_valid", out_valid, 0);
        @(posedge clk); #1;
        check("lat_out_valid", out_valid, 1);
        check("lit_add_sum", sum, 16'h2233);
        check("lit_add_flags", {cout, ovf, zero}, 3'b000);
        idle(3);

        one(16'h0005, 16'h0005, 2'b01, 1'b0);
        one(16'h0000, 16'h0001, 2'b01, 1'b0);
        one(16'h7FFF, 16'h0001, 2'b10, 1'b0);
        one(16'h8000, 16'hFFFF, 2'b10, 1'b0);
        one(16'h7FFF, 16'h0001, 2'b00, 1'b0);
        one(16'h0001, 16'h0001, 2'b00, 1'b1);
        one(16'h8000, 16'h8000, 2'b10, 1'b0);
        // ADDC then cin flips on the very next beat.
        send(16'hFFFF, 16'h0000, 2'b11, 1'b1);
        send(16'hFFFF, 16'h0000, 2'b11, 1'b0);
        idle(4);

        // Random back-to-back stream with a three-cycle output stall.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom));
                end
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(8);
        check("stream_drained", q.size(), 0);

        // Two beats in flight, then reset; only the next beat may emerge.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 2'b00, 1'b0);
        send(16'h3333, 16'h4444, 2'b00, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("post_rst_valid", out_valid, 0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        a = 16'h0001; b = 16'h0002; mode = 2'b00; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_rst_mid", out_valid, 0);
        @(posedge clk); #1;
        check("post_rst_out_valid", out_valid, 1);
        check("post_rst_sum", sum, 16'h0003);
        idle(6);
        check("final_drained", q.size(), 0);
        check("final_idle_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
